// File: rtl/spi_master.sv
// spi_master: clock-synchronous SPI master for the team's SPI slave.
// Sends 10-bit command words ({opcode[1:0], payload[7:0]}) as framed serial
// transactions on SS_n/MOSI and, for rd-data frames (opcode 11), collects the
// 8-bit reply from MISO.
// Optional feature macro: SPI_MASTER_RDCHK_EN. When defined, rd-data commands
// issued without a preceding rd-addr frame are dropped and flagged on err.
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE. The producer holds
// cmd_valid and cmd_data stable until that edge. rd_valid and err are
// single-cycle pulses with no back-pressure.
module spi_master #(
  parameter int MISO_DLY = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [9:0] sh;        // outgoing command word, MSB presented on MOSI
  logic [1:0] op;        // opcode of the frame in flight
  logic [3:0] cnt;       // per-state cycle counter, cleared on every state change
  logic [6:0] rx;        // first seven MISO samples of a reply
  logic       cnt_last;  // counter at the terminal value of the current state
  logic       accept;
  logic       reject;    // accepted rd-data command that must not be sent

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign dbg_state = state;

`ifdef SPI_MASTER_RDCHK_EN
  logic rd_pend;

  assign reject = accept && (cmd_data[9:8] == 2'b11) && !rd_pend;

  // Read-address-pending flag: set by a finished rd-addr frame, cleared by a finished rd-data frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else if (state == S_SHIFT && cnt_last && op == 2'b10) begin
      rd_pend <= 1'b1;
    end else if (state == S_READ && cnt_last) begin
      rd_pend <= 1'b0;
    end
  end

  // Error pulse lands in the first GAP cycle of a dropped command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= reject;
    end
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // Terminal count for the current state's counter.
  always_comb begin
    cnt_last = 1'b0;
    case (state)
      S_SHIFT: cnt_last = (cnt == 4'd9);
      S_WAIT:  cnt_last = (cnt == 4'(MISO_DLY - 1));
      S_READ:  cnt_last = (cnt == 4'd7);
      S_GAP:   cnt_last = (cnt == 4'(IDLE_GAP - 1));
      default: cnt_last = 1'b0;
    endcase
  end

  // State register; reset forces IDLE so SS_n rises asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and link outputs decoded from the current state.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    SS_n      = 1'b0;
    MOSI      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        SS_n      = 1'b1;
        if (accept) begin
          state_nx = reject ? S_GAP : S_SEL;
        end
      end
      S_SEL: begin
        MOSI     = sh[9];
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        MOSI = sh[9];
        if (cnt_last) begin
          state_nx = (op == 2'b11) ? S_WAIT : S_GAP;
        end
      end
      S_WAIT: begin
        if (cnt_last) begin
          state_nx = S_READ;
        end
      end
      S_READ: begin
        if (cnt_last) begin
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        SS_n = 1'b1;
        if (cnt_last) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        SS_n     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Cycle counter: restarts on each state change and holds at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (state_nx != state) begin
      cnt <= 4'd0;
    end else if (!cnt_last && state != S_IDLE && state != S_SEL) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Command latch, MOSI shifter and MISO reply capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= 10'd0;
      op       <= 2'b00;
      rx       <= 7'd0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        sh <= cmd_data;
        op <= cmd_data[9:8];
      end else if (state == S_SHIFT) begin
        sh <= {sh[8:0], 1'b0};
      end
      if (state == S_READ) begin
        rx <= {rx[5:0], MISO};
        if (cnt_last) begin
          rd_data  <= {rx, MISO};
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master.
// The reference model describes each frame by its cycle-level shape: how long
// SS_n is low, which command bit MOSI carries in each frame cycle, which cycles
// the slave drives the reply on MISO, and when the reply must appear.
module tb_spi_master;

  localparam int MISO_DLY = 2;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = 10'd0;
  logic       MISO = 1'b0;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       err;
  logic       SS_n;
  logic       MOSI;
  logic [2:0] dbg_state;

  spi_master #(.MISO_DLY(MISO_DLY), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];       // replies expected on rd_data, in order
  logic [7:0] exp_rd = 8'h00; // value rd_data must currently hold
  bit         rd_pend = 1'b0; // model of the read-address-pending rule

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver + per-cycle model check ----------------
  // Presents one command, then checks every cycle from SEL to the IDLE cycle
  // in which the next command may be accepted. Returns the cycle of SEL.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] reply,
                           input bit hold_next, input logic [9:0] next_cmd,
                           output int sel_cyc);
    int         budget;
    int         len;
    int         ex_mosi;
    bit         rej;
    bit         is_rd;
    logic [10:0] bits;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    budget    = 0;
    while (cmd_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("accept_wait", (budget < 200) ? 1 : 0, 1);
    rej = 1'b0;
`ifdef SPI_MASTER_RDCHK_EN
    rej = (cmd[9:8] == 2'b11) && !rd_pend;
`endif
    is_rd = (cmd[9:8] == 2'b11) && !rej;
    len   = rej ? 0 : (is_rd ? 11 + MISO_DLY + 8 : 11);
    if (is_rd) exp_q.push_back(reply);
    bits  = {cmd[9], cmd};  // SEL repeats the MSB before the 10 shift cycles
    sel_cyc = -1;
    @(posedge clk);         // accept edge
    for (int k = 1; k <= len + IDLE_GAP + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = hold_next;
        cmd_data  = hold_next ? next_cmd : 10'd0;
      end
      if (is_rd && k >= 12 + MISO_DLY && k <= 19 + MISO_DLY)
        MISO = reply[7 - (k - 12 - MISO_DLY)];
      else
        MISO = 1'($urandom_range(0, 1));
      if (SS_n === 1'b0 && sel_cyc < 0) sel_cyc = cyc;
      ex_mosi = 0;
      if (k <= 11 && k <= len) ex_mosi = int'(bits[11 - k]);
      if (is_rd && k == len + 1 && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      check("ss_n", SS_n, (k <= len) ? 0 : 1);
      check("mosi", MOSI, ex_mosi);
      check("rd_valid", rd_valid, (is_rd && k == len + 1) ? 1 : 0);
      check("rd_data", rd_data, exp_rd);
      check("err", err, (rej && k == 1) ? 1 : 0);
      check("busy", busy, (k <= len + IDLE_GAP) ? 1 : 0);
      check("cmd_ready", cmd_ready, (k == len + IDLE_GAP + 1) ? 1 : 0);
    end
    if (cmd[9:8] == 2'b10) rd_pend = 1'b1;
    else if (is_rd) rd_pend = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         s1;
    int         s2;
    logic [9:0] cmds[24];
    logic [7:0] rep;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ss_n", SS_n, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_err", err, 0);
    end

`ifdef SPI_MASTER_RDCHK_EN
    // rd-data with no preceding rd-addr: dropped with an err pulse.
    run_frame(10'h300, 8'h5A, 1'b0, 10'd0, s1);
    check("rdchk_no_ss", (s1 < 0) ? 1 : 0, 1);
`endif

    // Directed frames.
    run_frame(10'h0A5, 8'h00, 1'b0, 10'd0, s1);
    run_frame(10'h2C3, 8'h00, 1'b0, 10'd0, s1);
    run_frame(10'h300, 8'h3C, 1'b0, 10'd0, s1);
    check("rd_reply_3c", rd_data, 8'h3C);

    // Back-to-back writes with cmd_valid held: SEL-to-SEL spacing is the
    // 11 SS_n-low cycles plus IDLE_GAP plus the accepting IDLE cycle.
    run_frame(10'h05A, 8'h00, 1'b1, 10'h1F0, s1);
    run_frame(10'h1F0, 8'h00, 1'b0, 10'd0, s2);
    check("b2b_spacing", s2 - s1, 12 + IDLE_GAP);

    // Randomized command stream; rd-addr is biased in so rd-data frames run.
    for (int i = 0; i < 24; i++) begin
      cmds[i] = 10'($urandom_range(0, 1023));
      if (i % 4 == 2) cmds[i][9:8] = 2'b10;
      if (i % 4 == 3) cmds[i][9:8] = 2'b11;
    end
    for (int i = 0; i < 24; i++) begin
      rep = 8'($urandom_range(0, 255));
      run_frame(cmds[i], rep, (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0,
                (i < 23) ? cmds[i + 1] : 10'd0, s1);
    end

    // Reset in the middle of an rd-data frame.
    run_frame(10'h211, 8'h00, 1'b0, 10'd0, s1);
    cmd_valid = 1'b1;
    cmd_data  = 10'h3AA;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      MISO = 1'($urandom_range(0, 1));
    end
    check("mid_ss_low", SS_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", SS_n, 1);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_rd  = 8'h00;
    rd_pend = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_rst_rd_valid", rd_valid, 0);
      check("post_rst_ss_n", SS_n, 1);
      check("post_rst_rd_data", rd_data, 8'h00);
    end

    // Clean frames after the abandoned one.
    run_frame(10'h0C3, 8'h00, 1'b0, 10'd0, s1);
    run_frame(10'h2FF, 8'h00, 1'b0, 10'd0, s1);
    run_frame(10'h301, 8'hA7, 1'b0, 10'd0, s1);
    check("post_rst_reply", rd_data, 8'hA7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
